// File: rtl/ahb_poly_dma_pkg.sv
// Shared state encoding and bus constants for the polynomial-coefficient AHB DMA.
package ahb_poly_dma_pkg;

    typedef enum logic [6:0] {
        S_IDLE = 7'b000_0001,
        S_RD_A = 7'b000_0010,
        S_RD_D = 7'b000_0100,
        S_WR_A = 7'b000_1000,
        S_WR_D = 7'b001_0000,
        S_DONE = 7'b010_0000,
        S_ERR  = 7'b100_0000
    } dma_state_e;

    localparam logic [3:0]  HSIZE_128  = 4'b0100;
    localparam logic [31:0] BEAT_BYTES = 32'd16;

endpackage

// File: rtl/ahb_poly_dma_addrgen.sv
// Source/destination beat pointers and remaining-beat counter for the DMA.
module ahb_poly_dma_addrgen
    import ahb_poly_dma_pkg::*;
#(
    parameter int unsigned LENWIDTH = 14
) (
    input  logic                hclk,
    input  logic                hresetn,
    input  logic                load,
    input  logic                advance,
    input  logic [31:0]         src_in,
    input  logic [31:0]         dst_in,
    input  logic [LENWIDTH-1:0] len_in,
    output logic [31:0]         src_ptr,
    output logic [31:0]         dst_ptr,
    output logic                last_c
);

    logic [LENWIDTH-1:0] remaining;
    logic                unused_low;

    // Beat alignment drops the byte offset; those bits are deliberately unused.
    assign unused_low = ^{src_in[3:0], dst_in[3:0]};

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
        end else if (load) begin
            src_ptr   <= {src_in[31:4], 4'h0};
            dst_ptr   <= {dst_in[31:4], 4'h0};
            remaining <= len_in;
        end else if (advance) begin
            src_ptr   <= src_ptr + BEAT_BYTES;
            dst_ptr   <= dst_ptr + BEAT_BYTES;
            remaining <= remaining - LENWIDTH'(1);
        end
    end

    assign last_c = (remaining == LENWIDTH'(1));

endmodule

// File: rtl/ahb_poly_dma.sv
// Non-pipelined AHB-lite master copying 128-bit coefficient beats between regions.
// Optional constant-fill mode is compiled in with DMA_FILL_EN.
module ahb_poly_dma
    import ahb_poly_dma_pkg::*;
#(
    parameter int unsigned DWIDTH   = 128,
    parameter int unsigned LENWIDTH = 14
) (
    input  logic                hclk,
    input  logic                hresetn,
    input  logic                start,
    input  logic [31:0]         src_addr,
    input  logic [31:0]         dst_addr,
    input  logic [LENWIDTH-1:0] len,
    input  logic                fill_en,
    input  logic [DWIDTH-1:0]   fill_val,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                hsel,
    output logic [31:0]         haddr,
    output logic [3:0]          hsize,
    output logic                hwrite,
    output logic [DWIDTH-1:0]   hwdata,
    input  logic [DWIDTH-1:0]   hrdata,
    input  logic                hready,
    input  logic                hresp
);

    dma_state_e          state;
    logic [DWIDTH-1:0]   buffer;
    logic                fill_mode;
    logic                use_fill_c;
    logic [DWIDTH-1:0]   fill_val_c;
    logic                load_c;
    logic                advance_c;
    logic                last_c;
    logic [31:0]         src_ptr;
    logic [31:0]         dst_ptr;

`ifdef DMA_FILL_EN
    assign use_fill_c = fill_en;
    assign fill_val_c = fill_val;
`else
    logic unused_fill;
    assign use_fill_c  = 1'b0;
    assign fill_val_c  = '0;
    assign unused_fill = ^{fill_en, fill_val};
`endif

    assign load_c    = (state == S_IDLE) && start && (len != '0);
    assign advance_c = (state == S_WR_D) && hready && !hresp;

    ahb_poly_dma_addrgen #(
        .LENWIDTH (LENWIDTH)
    ) u_addrgen (
        .hclk    (hclk),
        .hresetn (hresetn),
        .load    (load_c),
        .advance (advance_c),
        .src_in  (src_addr),
        .dst_in  (dst_addr),
        .len_in  (len),
        .src_ptr (src_ptr),
        .dst_ptr (dst_ptr),
        .last_c  (last_c)
    );

    // Control FSM; bus outputs are set on the edge that enters each phase.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            hsel      <= 1'b0;
            haddr     <= '0;
            hsize     <= '0;
            hwrite    <= 1'b0;
            hwdata    <= '0;
            buffer    <= '0;
            fill_mode <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            busy      <= 1'b1;
                            fill_mode <= use_fill_c;
                            hsel      <= 1'b1;
                            hsize     <= HSIZE_128;
                            if (use_fill_c) begin
                                state  <= S_WR_A;
                                hwrite <= 1'b1;
                                haddr  <= {dst_addr[31:4], 4'h0};
                                buffer <= fill_val_c;
                            end else begin
                                state  <= S_RD_A;
                                hwrite <= 1'b0;
                                haddr  <= {src_addr[31:4], 4'h0};
                            end
                        end
                    end
                end
                S_RD_A: begin
                    if (hready) begin
                        state <= S_RD_D;
                        hsel  <= 1'b0;
                        hsize <= '0;
                    end
                end
                S_RD_D: begin
                    if (hresp) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (hready) begin
                        state  <= S_WR_A;
                        buffer <= hrdata;
                        hsel   <= 1'b1;
                        hsize  <= HSIZE_128;
                        hwrite <= 1'b1;
                        haddr  <= dst_ptr;
                    end
                end
                S_WR_A: begin
                    if (hready) begin
                        state  <= S_WR_D;
                        hsel   <= 1'b0;
                        hsize  <= '0;
                        hwrite <= 1'b0;
                        hwdata <= buffer;
                    end
                end
                S_WR_D: begin
                    if (hresp) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (hready) begin
                        if (last_c) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (fill_mode) begin
                            state  <= S_WR_A;
                            hsel   <= 1'b1;
                            hsize  <= HSIZE_128;
                            hwrite <= 1'b1;
                            haddr  <= dst_ptr + BEAT_BYTES;
                        end else begin
                            state  <= S_RD_A;
                            hsel   <= 1'b1;
                            hsize  <= HSIZE_128;
                            hwrite <= 1'b0;
                            haddr  <= src_ptr + BEAT_BYTES;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_poly_dma.sv
// Randomized self-checking bench for ahb_poly_dma with a memory-backed AHB slave model.
module tb_ahb_poly_dma;

    localparam int unsigned DW = 128;
    localparam int unsigned LW = 14;

`ifdef DMA_FILL_EN
    localparam bit FILL_BUILD = 1'b1;
`else
    localparam bit FILL_BUILD = 1'b0;
`endif

    logic          hclk = 1'b0;
    logic          hresetn;
    logic          start;
    logic [31:0]   src_addr, dst_addr;
    logic [LW-1:0] len;
    logic          fill_en;
    logic [DW-1:0] fill_val;
    logic          busy, done, err, hsel, hwrite;
    logic [31:0]   haddr;
    logic [3:0]    hsize;
    logic [DW-1:0] hwdata, hrdata;
    logic          hready, hresp;

    ahb_poly_dma #(.DWIDTH(DW), .LENWIDTH(LW)) dut (
        .hclk(hclk), .hresetn(hresetn), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .fill_en(fill_en), .fill_val(fill_val),
        .busy(busy), .done(done), .err(err), .hsel(hsel), .haddr(haddr),
        .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    int vectors, miscompares;
    int cyc = 0, t0 = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    // Slave memory, observed traffic and reference expectations
    logic [DW-1:0] mem [logic [31:0]];
    logic [31:0]   wr_a[$], rd_log[$], exp_wa[$], exp_ra[$];
    logic [DW-1:0] wr_d[$], exp_wd[$];

    bit          dp_valid, dp_write, dp_err, prev_addr_wait, last_wr_done, wr_done_now;
    logic [31:0] dp_addr, held_addr;
    logic        held_write;
    bit          wait_mode;
    int          wait_pct, err_on_read, reads_seen, waits, hold_viol, size_viol;
    int          done_cyc, err_cyc, busy_first, busy_last, busy_cnt, hsel_cnt, done_cnt;
    logic        busy_at_err;

    function automatic logic [DW-1:0] bg(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a, a + 32'h1234_5678, a ^ 32'hDEAD_BEEF};
    endfunction

    function automatic logic [DW-1:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return bg(a);
    endfunction

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit roll_wait();
        return (wait_pct > 0) && (int'($urandom_range(99)) < wait_pct);
    endfunction

    // Reference: sequential beat-by-beat copy (or fill) over the current memory image
    task automatic build_expected(input logic [31:0] s, input logic [31:0] d, input int n,
                                  input bit fill, input logic [DW-1:0] fv);
        logic [DW-1:0] ov [logic [31:0]];
        logic [31:0]   sa, da;
        logic [DW-1:0] v;
        exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
        sa = {s[31:4], 4'h0};
        da = {d[31:4], 4'h0};
        for (int i = 0; i < n; i++) begin
            if (fill) v = fv;
            else begin
                exp_ra.push_back(sa);
                v = ov.exists(sa) ? ov[sa] : rd_mem(sa);
            end
            exp_wa.push_back(da);
            exp_wd.push_back(v);
            ov[da] = v;
            sa = sa + 32'd16;
            da = da + 32'd16;
        end
    endtask

    function automatic int wr_errs();
        int e = 0;
        if (wr_a.size() != exp_wa.size()) e++;
        for (int i = 0; i < wr_a.size() && i < exp_wa.size(); i++)
            if (wr_a[i] !== exp_wa[i] || wr_d[i] !== exp_wd[i]) e++;
        return e;
    endfunction

    function automatic int rd_errs();
        int e = 0;
        if (rd_log.size() != exp_ra.size()) e++;
        for (int i = 0; i < rd_log.size() && i < exp_ra.size(); i++)
            if (rd_log[i] !== exp_ra[i]) e++;
        return e;
    endfunction

    // Slave + monitor: everything is decided on the falling edge, mid-cycle
    always @(negedge hclk) begin : slave
        wr_done_now = 1'b0;
        if (!hresetn) begin
            dp_valid = 0; prev_addr_wait = 0; last_wr_done = 0;
            hready = 1'b1; hresp = 1'b0;
        end else begin
            if (busy) begin
                if (busy_first < 0) busy_first = cyc - t0;
                busy_last = cyc - t0;
                busy_cnt++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc - t0;
            end
            if (err && err_cyc < 0) begin
                err_cyc = cyc - t0;
                busy_at_err = busy;
            end
            if (hsel) hsel_cnt++;
            if (hsize !== (hsel ? 4'b0100 : 4'b0000)) size_viol++;
            hready = 1'b1;
            hresp  = 1'b0;
            if (dp_valid) begin
                prev_addr_wait = 0;
                if (dp_err) begin
                    hresp = 1'b1; hready = 1'b0; dp_valid = 0;
                end else if (roll_wait()) begin
                    hready = 1'b0; hrdata = rnd128(); waits++;
                end else if (dp_write) begin
                    wr_a.push_back(dp_addr);
                    wr_d.push_back(hwdata);
                    mem[dp_addr] = hwdata;
                    dp_valid = 0;
                    wr_done_now = 1'b1;
                end else begin
                    hrdata = rd_mem(dp_addr);
                    dp_valid = 0;
                end
            end else if (hsel) begin
                if (prev_addr_wait && (haddr !== held_addr || hwrite !== held_write)) hold_viol++;
                if ((wait_mode && last_wr_done && !hwrite) || roll_wait()) begin
                    hready = 1'b0; waits++;
                    prev_addr_wait = 1; held_addr = haddr; held_write = hwrite;
                end else begin
                    prev_addr_wait = 0;
                    dp_valid = 1; dp_addr = haddr; dp_write = hwrite; dp_err = 0;
                    if (!hwrite) begin
                        rd_log.push_back(haddr);
                        reads_seen++;
                        dp_err = (reads_seen == err_on_read);
                    end
                end
            end else begin
                prev_addr_wait = 0;
            end
            last_wr_done = wr_done_now;
        end
    end

    task automatic kick(input logic [31:0] s, input logic [31:0] d, input int n,
                        input bit fe, input logic [DW-1:0] fv);
        @(negedge hclk); #1;
        src_addr = s; dst_addr = d; len = LW'(n); fill_en = fe; fill_val = fv; start = 1'b1;
        wr_a.delete(); wr_d.delete(); rd_log.delete();
        done_cyc = -1; err_cyc = -1; busy_first = -1; busy_last = -1; busy_at_err = 1'bx;
        busy_cnt = 0; hsel_cnt = 0; done_cnt = 0; waits = 0; reads_seen = 0;
        hold_viol = 0; size_viol = 0;
        t0 = cyc;
        @(negedge hclk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge hclk); #1;
            if (done_cnt > 0 || err_cyc >= 0) begin ok = 1'b1; break; end
        end
        repeat (2) begin @(negedge hclk); #1; end
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        repeat (3) @(negedge hclk);
        #1;
        vectors++; if ({busy, done, err, hsel, hwrite} !== 5'b0) begin miscompares++;
            $display("FAIL reset_ctrl got %b want 00000", {busy, done, err, hsel, hwrite}); end
        vectors++; if (haddr !== 32'h0) begin miscompares++;
            $display("FAIL reset_haddr got %h want 0", haddr); end
        vectors++; if (hsize !== 4'h0) begin miscompares++;
            $display("FAIL reset_hsize got %h want 0", hsize); end
        vectors++; if (hwdata !== '0) begin miscompares++;
            $display("FAIL reset_hwdata got %h want 0", hwdata); end
        hresetn = 1'b1;
        repeat (2) @(negedge hclk);
    endtask

    task automatic test_copy_basic();
        bit ok;
        wait_mode = 0; wait_pct = 0; err_on_read = 0;
        for (int i = 0; i < 4; i++) mem[32'(i * 16)] = rnd128();
        build_expected(32'h0, 32'h4000, 4, 1'b0, '0);
        kick(32'h0, 32'h4000, 4, 1'b0, '0);
        wait_end(100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL basic_timeout got none want done"); end
        vectors++; if (done_cyc !== 17) begin miscompares++;
            $display("FAIL basic_done_cycle got %0d want 17", done_cyc); end
        vectors++; if (busy_first !== 1 || busy_last !== 16 || busy_cnt !== 16) begin miscompares++;
            $display("FAIL basic_busy got %0d..%0d (%0d) want 1..16 (16)", busy_first, busy_last, busy_cnt); end
        vectors++; if (rd_errs() !== 0) begin miscompares++;
            $display("FAIL basic_reads got %0d bad want 0", rd_errs()); end
        vectors++; if (wr_errs() !== 0) begin miscompares++;
            $display("FAIL basic_writes got %0d bad want 0", wr_errs()); end
        vectors++; if (err_cyc !== -1 || done_cnt !== 1) begin miscompares++;
            $display("FAIL basic_flags got err@%0d done x%0d want none, x1", err_cyc, done_cnt); end
        vectors++; if (size_viol !== 0) begin miscompares++;
            $display("FAIL basic_hsize got %0d bad want 0", size_viol); end
    endtask

    task automatic test_wait_after_write();
        bit ok;
        wait_mode = 1; wait_pct = 0; err_on_read = 0;
        for (int i = 0; i < 4; i++) mem[32'(i * 16)] = rnd128();
        build_expected(32'h0, 32'h4000, 4, 1'b0, '0);
        kick(32'h0, 32'h4000, 4, 1'b0, '0);
        wait_end(100, ok);
        vectors++; if (!ok || done_cyc !== 20) begin miscompares++;
            $display("FAIL wait_done_cycle got %0d want 20", done_cyc); end
        vectors++; if (hold_viol !== 0) begin miscompares++;
            $display("FAIL wait_addr_hold got %0d bad want 0", hold_viol); end
        vectors++; if (wr_errs() !== 0) begin miscompares++;
            $display("FAIL wait_writes got %0d bad want 0", wr_errs()); end
        vectors++; if (rd_errs() !== 0) begin miscompares++;
            $display("FAIL wait_reads got %0d bad want 0", rd_errs()); end
        wait_mode = 0;
    endtask

    task automatic test_error();
        bit ok;
        wait_mode = 0; wait_pct = 0; err_on_read = 3;
        for (int i = 0; i < 5; i++) mem[32'h100 + 32'(i * 16)] = rnd128();
        build_expected(32'h100, 32'h8000, 5, 1'b0, '0);
        while (exp_wa.size() > 2) begin void'(exp_wa.pop_back()); void'(exp_wd.pop_back()); end
        kick(32'h100, 32'h8000, 5, 1'b0, '0);
        wait_end(100, ok);
        repeat (3) @(negedge hclk);
        #1;
        vectors++; if (!ok || err_cyc !== 11) begin miscompares++;
            $display("FAIL err_cycle got %0d want 11", err_cyc); end
        vectors++; if (busy_at_err !== 1'b0) begin miscompares++;
            $display("FAIL err_busy got %b want 0", busy_at_err); end
        vectors++; if (done_cnt !== 0) begin miscompares++;
            $display("FAIL err_no_done got %0d want 0", done_cnt); end
        vectors++; if (wr_errs() !== 0) begin miscompares++;
            $display("FAIL err_writes got %0d writes want 2 matching", wr_a.size()); end
        vectors++; if (rd_log.size() !== 3 || hsel_cnt !== 5) begin miscompares++;
            $display("FAIL err_bus got reads %0d sel %0d want 3 5", rd_log.size(), hsel_cnt); end
        vectors++; if (err !== 1'b1) begin miscompares++;
            $display("FAIL err_sticky got %b want 1", err); end
        err_on_read = 0;
    endtask

    task automatic test_len_zero();
        bit ok;
        kick($urandom, $urandom, 0, 1'b0, '0);
        wait_end(20, ok);
        vectors++; if (!ok || done_cyc !== 1 || done_cnt !== 1) begin miscompares++;
            $display("FAIL len0_done got cyc %0d x%0d want 1 x1", done_cyc, done_cnt); end
        vectors++; if (hsel_cnt !== 0 || busy_cnt !== 0) begin miscompares++;
            $display("FAIL len0_idle got sel %0d busy %0d want 0 0", hsel_cnt, busy_cnt); end
        vectors++; if (err_cyc !== -1 || err !== 1'b0) begin miscompares++;
            $display("FAIL len0_err_clear got err@%0d err=%b want none 0", err_cyc, err); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [31:0] s, d;
        for (int i = 0; i < 3; i++) mem[32'h200 + 32'(i * 16)] = rnd128();
        build_expected(32'h200, 32'h9000, 3, 1'b0, '0);
        kick(32'h200, 32'h9000, 3, 1'b0, '0);
        repeat (7) @(negedge hclk);
        #1;
        vectors++; if (hwdata !== exp_wd[1]) begin miscompares++;
            $display("FAIL rstmid_beat2 got %h want %h", hwdata, exp_wd[1]); end
        hresetn = 1'b0;
        #1;
        vectors++; if ({busy, done, err, hsel, hwrite} !== 5'b0 || haddr !== 32'h0 ||
                       hsize !== 4'h0 || hwdata !== '0) begin miscompares++;
            $display("FAIL rstmid_outputs got ctrl %b addr %h size %h want all 0",
                     {busy, done, err, hsel, hwrite}, haddr, hsize); end
        repeat (2) @(negedge hclk);
        #1;
        hresetn = 1'b1;
        s = $urandom; d = $urandom;
        mem[{s[31:4], 4'h0}] = rnd128();
        build_expected(s, d, 1, 1'b0, '0);
        kick(s, d, 1, 1'b0, '0);
        wait_end(50, ok);
        vectors++; if (!ok || done_cyc !== 5) begin miscompares++;
            $display("FAIL rstmid_done got %0d want 5", done_cyc); end
        vectors++; if (wr_errs() !== 0 || rd_errs() !== 0) begin miscompares++;
            $display("FAIL rstmid_copy got %0d/%0d bad want 0/0", wr_errs(), rd_errs()); end
    endtask

    task automatic test_fill();
        bit ok;
        logic [DW-1:0] fv;
        int exp_done;
        fv = {16{8'hA5}};
        for (int i = 0; i < 3; i++) mem[32'h300 + 32'(i * 16)] = rnd128();
        build_expected(32'h300, 32'h6000, 3, FILL_BUILD, fv);
        exp_done = FILL_BUILD ? 7 : 13;
        kick(32'h300, 32'h6000, 3, 1'b1, fv);
        wait_end(60, ok);
        vectors++; if (!ok || done_cyc !== exp_done) begin miscompares++;
            $display("FAIL fill_done got %0d want %0d", done_cyc, exp_done); end
        vectors++; if (wr_errs() !== 0) begin miscompares++;
            $display("FAIL fill_writes got %0d bad want 0", wr_errs()); end
        vectors++; if (rd_errs() !== 0) begin miscompares++;
            $display("FAIL fill_reads got %0d reads want %0d", rd_log.size(), exp_ra.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok, fe, fill_eff;
        logic [31:0] s, d;
        logic [DW-1:0] fv;
        int n, exp_done;
        for (int it = 0; it < 6; it++) begin
            s  = (it == 0) ? 32'hFFFF_FFE7 : $urandom;
            d  = $urandom;
            n  = int'($urandom_range(1, 6));
            fe = 1'($urandom_range(0, 1));
            fv = rnd128();
            fill_eff  = fe & FILL_BUILD;
            wait_pct  = 20;
            wait_mode = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) mem[{s[31:4], 4'h0} + 32'(i * 16)] = rnd128();
            build_expected(s, d, n, fill_eff, fv);
            kick(s, d, n, fe, fv);
            @(negedge hclk); #1;
            start = 1'b1; src_addr = $urandom; dst_addr = $urandom; len = LW'(7);
            @(negedge hclk); #1;
            start = 1'b0;
            wait_end(400, ok);
            exp_done = (fill_eff ? 2 : 4) * n + 1 + waits;
            vectors++; if (!ok || done_cyc !== exp_done) begin miscompares++;
                $display("FAIL rand%0d_done got %0d want %0d", it, done_cyc, exp_done); end
            vectors++; if (wr_errs() !== 0) begin miscompares++;
                $display("FAIL rand%0d_writes got %0d bad want 0", it, wr_errs()); end
            vectors++; if (rd_errs() !== 0) begin miscompares++;
                $display("FAIL rand%0d_reads got %0d bad want 0", it, rd_errs()); end
            vectors++; if (hold_viol !== 0 || size_viol !== 0) begin miscompares++;
                $display("FAIL rand%0d_phase got hold %0d size %0d want 0 0", it, hold_viol, size_viol); end
            vectors++; if (err_cyc !== -1 || done_cnt !== 1) begin miscompares++;
                $display("FAIL rand%0d_flags got err@%0d done x%0d want none x1", it, err_cyc, done_cnt); end
        end
        wait_pct = 0; wait_mode = 0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        hresetn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        fill_en = 1'b0; fill_val = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
        wait_mode = 0; wait_pct = 0; err_on_read = 0;
        done_cyc = -1; err_cyc = -1; busy_first = -1; busy_last = -1;
        busy_cnt = 0; hsel_cnt = 0; done_cnt = 0; waits = 0; reads_seen = 0;
        hold_viol = 0; size_viol = 0;
        test_reset();
        test_copy_basic();
        test_wait_after_write();
        test_error();
        test_len_zero();
        test_reset_mid();
        test_fill();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/ahb_poly_dma.md
Name: ahb_poly_dma

Overview:
- AHB-lite master that copies a block of 128-bit polynomial coefficient beats from a source region to a destination region.
- Sits directly upstream of the coefficient SRAM wrapper slave and drives its hsel/haddr/hsize/hwrite/hwdata inputs.
- Started by a host/control block with a one-cycle pulse; reports done/error.
- Non-pipelined: one AHB transfer outstanding at a time; tolerates slave-inserted wait states and the wrapper's write-then-read WAIT cycle.

Parameters:
- DWIDTH, 128, AHB data width in bits; beat address increment = DWIDTH/8.
- LENWIDTH, 14, width of the beat-count input; max transfer length 2^LENWIDTH-1 beats.

Ports:
- hclk  in  1  clock
- hresetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- src_addr  in  32  source byte address; bits [3:0] ignored, forced to 0
- dst_addr  in  32  destination byte address; bits [3:0] forced to 0
- len  in  LENWIDTH  number of beats to copy
- fill_en  in  1  constant-fill request (used only with DMA_FILL_EN)
- fill_val  in  DWIDTH  fill pattern (used only with DMA_FILL_EN)
- busy  out  1  high from accepted start until done/err
- done  out  1  one-cycle pulse on normal completion
- err  out  1  sticky error flag; cleared by next accepted start
- hsel  out  1  AHB select
- haddr  out  32  AHB address
- hsize  out  4  fixed 4'b0100 (128-bit) whenever hsel=1; 0 otherwise
- hwrite  out  1  AHB write control
- hwdata  out  DWIDTH  write data, valid in write data phase
- hrdata  in  DWIDTH  read data
- hready  in  1  AHB ready
- hresp  in  1  AHB error response

Behaviour:
- Reset: busy=0, done=0, err=0, hsel=0, haddr=0, hsize=0, hwrite=0, hwdata=0. Internal state is IDLE; counters and data buffer are 0. Reset mid-copy aborts immediately with no further bus activity.
- States (one-hot):
  - IDLE
    - start && len!=0: latch src/dst/len; busy=1; go RD_A.
    - start && len==0: done pulse next cycle; busy stays 0; no bus activity.
  - RD_A: hsel=1, hwrite=0, haddr=src_ptr. Address accepted on a cycle with hready=1; go RD_D. While hready=0, hold all address-phase outputs stable.
  - RD_D: hsel=0. On hready=1, capture hrdata into a DWIDTH buffer; go WR_A.
  - WR_A: hsel=1, hwrite=1, haddr=dst_ptr. Accepted on hready=1; go WR_D.
  - WR_D: hsel=0, hwdata=buffer, held stable until hready=1. On completion: src_ptr+=16, dst_ptr+=16, remaining-1. If remaining becomes 0, go DONE; else go RD_A.
  - DONE: done=1 for one cycle, busy=0; go IDLE.
  - ERR: err=1 (sticky), busy=0, no done pulse; go IDLE.
- hresp=1 in any data phase → ERR on the cycle it is seen; the current beat is discarded; pointers are not advanced.
- Read-after-write: the next RD_A follows WR_D; the slave may deassert hready for one cycle (WAIT). The master holds the address until hready=1. No data is lost.
- Latency per beat with no wait states: 4 cycles. Total for N beats: 4N cycles from the cycle after start, plus 1 for DONE.
- Pointers are 32-bit and wrap modulo 2^32 with no error. Latched inputs are ignored while busy; start while busy is ignored.
- hwdata is driven from the buffer only in WR_D; it holds its previous value otherwise.

Optional Feature:
- DMA_FILL_EN defined: fill_en latched at start. If fill_en=1, RD_A/RD_D are skipped; buffer=fill_val; the sequence is WR_A→WR_D per beat. Per-beat latency is 2 cycles.
- DMA_FILL_EN undefined: fill_en and fill_val are ignored; always copy.

Decomposition:
- Shared package: state encoding constants (IDLE, RD_A, RD_D, WR_A, WR_D, DONE, ERR), HSIZE_128=4'b0100, BEAT_BYTES=16.
- One natural sub-module: ahb_poly_dma_addrgen. Holds the src/dst pointers and the remaining-beat counter, with load/advance/last outputs.

Test Plan:
- start, src=0x0000, dst=0x4000, len=4, zero-wait slave → reads 0x0,0x10,0x20,0x30; writes 0x4000..0x4030 with matching data; done at cycle 17; busy high cycles 1-16.
- Same with the wrapper's WAIT after each write → address held during hready=0; data intact; done delayed by 1 cycle per beat after the first.
- hresp=1 on the 3rd read data phase, len=5 → err=1, no done, exactly 2 writes issued, busy=0 next cycle.
- start with len=0 → done pulse next cycle; hsel never asserted; err cleared.
- hresetn low during WR_D of beat 2 → all outputs 0 immediately; after release, a new start with len=1 copies correctly.
- DMA_FILL_EN, fill_en=1, fill_val=0xA5..A5, len=3 → only writes to dst, dst+16, dst+32, all 0xA5..A5; done at cycle 7.
